// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants: hazard-controller state encoding, the x0 register index and
// the default mul/div watchdog limit.
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StMdWait  = 2'd1;
  localparam logic [1:0] StMdDrain = 2'd2;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int unsigned MD_MAX_DEFAULT = 64;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with a synchronous clear that overrides the increment.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and a freeze of
// IF/ID/EX while a multicycle mul/div runs, guarded by a watchdog.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned MD_MAX = MD_MAX_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_br_taken,
  input  logic             ex_md_start,
  input  logic             md_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             md_timeout,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WdW = (MD_MAX > 1) ? $clog2(MD_MAX) : 1;

  logic [1:0]     state_q, state_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic           load_use;
  logic           wd_last;

  assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign wd_last  = (wd_q == WdW'(MD_MAX - 1));

  always_comb begin
    state_d    = state_q;
    wd_d       = '0;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    md_timeout = 1'b0;
    case (state_q)
      StRun: begin
        // A taken branch squashes everything younger, including a stalled load-use pair.
        if (ex_br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else begin
          if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
          end
          if (ex_md_start) begin
            state_d = StMdWait;
          end
        end
      end
      StMdWait: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        if (md_done) begin
          state_d = StMdDrain;
        end else if (wd_last) begin
          md_timeout = 1'b1;
          state_d    = StMdDrain;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StMdDrain: begin
        state_d = StRun;
      end
      default: begin
        state_d = StRun;
      end
    endcase
    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      md_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (~pc_en),
    .clr_i (cnt_clr),
    .cnt_o (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a RUN-state vector table plus mul/div, watchdog,
// reset and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CntW  = 4;
  localparam int unsigned MdMax = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [4:0]      id_rs1, id_rs2, ex_rd;
  logic            id_use_rs1, id_use_rs2, ex_mem_read, ex_br_taken, ex_md_start, md_done;
  logic            pc_en, ifid_en, idex_en, ifid_flush, idex_flush, md_timeout, cnt_clr;
  logic [CntW-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  int m_cnt = 0;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic [4:0] exp;  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush}
  } vec_t;

  vec_t vecs[12];

  pipe_hazard_ctrl #(
    .CNT_W  (CntW),
    .MD_MAX (MdMax)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .ex_br_taken (ex_br_taken),
    .ex_md_start (ex_md_start),
    .md_done     (md_done),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .md_timeout  (md_timeout),
    .cnt_clr     (cnt_clr),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hz(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                        input logic use2, input logic [4:0] rd, input logic mr,
                        input logic br);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = use1; id_use_rs2 = use2;
    ex_rd = rd; ex_mem_read = mr; ex_br_taken = br;
  endtask

  task automatic chk_outs(input string name, input logic [4:0] exp);
    chk(name, {27'd0, pc_en, ifid_en, idex_en, ifid_flush, idex_flush}, {27'd0, exp});
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    m_cnt = 0;
  endtask

  // md_start in cycle 0; done_at==0 means md_done never comes and the watchdog fires.
  task automatic run_md(input string name, input int done_at);
    int n;
    n = (done_at == 0) ? MdMax : done_at;
    clear_cnt();
    set_hz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    ex_md_start = 1'b1;
    #2 chk_outs({name, "_start"}, 5'b11100);
    tick();
    ex_md_start = 1'b0;
    for (int c = 1; c <= n; c++) begin
      md_done = (c == done_at);
      #2;
      chk_outs({name, "_wait"}, 5'b00000);
      chk({name, "_timeout"}, {31'd0, md_timeout}, {31'd0, (done_at == 0) && (c == n)});
      tick();
    end
    md_done = 1'b0;
    chk({name, "_cnt"}, {28'd0, stall_cnt}, n);
    // Drain ignores a load-use hazard; the following RUN cycle honours it.
    set_hz(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    #2;
    chk_outs({name, "_drain"}, 5'b11100);
    chk({name, "_drain_to"}, {31'd0, md_timeout}, 32'd0);
    tick();
    #2 chk_outs({name, "_run"}, 5'b00101);
    tick();
    set_hz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    m_cnt = n + 1;
    chk({name, "_cnt2"}, {28'd0, stall_cnt}, m_cnt);
  endtask

  initial begin
    //           rs1    rs2    u1    u2    rd     mr    br    exp
    vecs[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b11100};
    vecs[1]  = '{5'd1,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 5'b00101};
    vecs[2]  = '{5'd1,  5'd5,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 5'b11100};
    vecs[3]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 5'b11100};
    vecs[4]  = '{5'd7,  5'd2,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 5'b00101};
    vecs[5]  = '{5'd7,  5'd2,  1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 5'b11100};
    vecs[6]  = '{5'd7,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 5'b11100};
    vecs[7]  = '{5'd4,  5'd5,  1'b0, 1'b1, 5'd5,  1'b1, 1'b1, 5'b11111};
    vecs[8]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 5'b11111};
    vecs[9]  = '{5'd5,  5'd6,  1'b0, 1'b1, 5'd5,  1'b1, 1'b0, 5'b11100};
    vecs[10] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 1'b0, 5'b00101};
    vecs[11] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'b11100};

    rst = 1'b1;
    cnt_clr = 1'b0; ex_md_start = 1'b0; md_done = 1'b0;
    set_hz(5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0);
    #2;
    chk_outs("reset_outs", 5'b00000);
    chk("reset_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("reset_timeout", {31'd0, md_timeout}, 32'd0);
    tick();
    rst = 1'b0;
    set_hz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();

    for (int i = 0; i < 12; i++) begin
      set_hz(vecs[i].rs1, vecs[i].rs2, vecs[i].use1, vecs[i].use2, vecs[i].rd, vecs[i].mr,
             vecs[i].br);
      #2;
      chk_outs($sformatf("vec%0d", i), vecs[i].exp);
      tick();
      if (!vecs[i].exp[4] && m_cnt < 15) m_cnt++;
      chk($sformatf("vec%0d_cnt", i), {28'd0, stall_cnt}, m_cnt);
    end

    run_md("md5", 5);
    run_md("md_tie", MdMax);
    run_md("md_wdog", 0);

    // Reset in the third MD_WAIT cycle.
    clear_cnt();
    ex_md_start = 1'b1;
    tick();
    ex_md_start = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk_outs("rst_mid_outs", 5'b00000);
    chk("rst_mid_cnt", {28'd0, stall_cnt}, 32'd0);
    chk("rst_mid_timeout", {31'd0, md_timeout}, 32'd0);
    tick();
    rst = 1'b0;
    #2 chk_outs("rst_after", 5'b11100);
    tick();
    chk("rst_after_cnt", {28'd0, stall_cnt}, 32'd0);
    set_hz(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0);
    #2 chk_outs("rst_after_run", 5'b00101);

    // Hold the hazard until the counter saturates, then clear while still stalling.
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt", {28'd0, stall_cnt}, 32'd15);
    tick();
    chk("sat_hold", {28'd0, stall_cnt}, 32'd15);
    cnt_clr = 1'b1;
    tick();
    chk("clr_prio", {28'd0, stall_cnt}, 32'd0);
    cnt_clr = 1'b0;
    tick();
    chk("clr_resume", {28'd0, stall_cnt}, 32'd1);
    set_hz(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the stall-cycle counter.
REQ-002 SHALL have parameter MD_MAX, default 64: maximum number of cycles to wait for md_done before timeout.
REQ-003 SHALL have port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, 5 each: source register indices of the instruction in ID.
REQ-006 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: the ID instruction reads that source.
REQ-007 SHALL have ports ex_rd (input, 5) and ex_mem_read (input, 1): destination of the EX instruction, and whether it is a load.
REQ-008 SHALL have port ex_br_taken, input, 1: taken branch or jump resolved in EX this cycle.
REQ-009 SHALL have ports ex_md_start (input, 1) and md_done (input, 1): a multicycle mul/div enters EX; the unit reports its result ready.
REQ-010 SHALL have ports pc_en, ifid_en and idex_en, output, 1 each: stage-register enables.
REQ-011 SHALL have ports ifid_flush and idex_flush, output, 1 each: insert a bubble into that stage register.
REQ-012 SHALL have ports md_timeout (output, 1): one-cycle pulse on watchdog expiry; cnt_clr (input, 1): clear the counter; stall_cnt (output, CNT_W): stall-cycle counter.

Function
REQ-013 SHALL implement states RUN, MD_WAIT and MD_DRAIN.
REQ-014 In RUN with no hazard, SHALL drive pc_en=ifid_en=idex_en=1 and both flushes=0.
REQ-015 Load-use hazard SHALL be defined as: ex_mem_read && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-016 On a load-use hazard in RUN, SHALL drive pc_en=0, ifid_en=0, idex_flush=1 in the same cycle (combinational; exactly one bubble per occurrence).
REQ-017 On ex_br_taken in RUN, SHALL drive pc_en=1, ifid_flush=1, idex_flush=1 in the same cycle.
REQ-018 ex_br_taken SHALL take priority over a load-use hazard in the same cycle (branch outputs only).
REQ-019 On ex_md_start in RUN, SHALL transition to MD_WAIT next cycle; in the start cycle, outputs follow REQ-014 to REQ-018.
REQ-020 ex_md_start with ex_br_taken in the same cycle SHALL be impossible by construction; if it occurs, the branch takes priority and no transition occurs.
REQ-021 In MD_WAIT, SHALL drive pc_en=ifid_en=idex_en=0 and both flushes=0, freezing IF, ID and EX.
REQ-022 In MD_WAIT, md_done=1 SHALL move the FSM to MD_DRAIN next cycle.
REQ-023 In MD_DRAIN, SHALL drive the RUN no-hazard outputs for one cycle, then return to RUN; hazard inputs are ignored in MD_DRAIN.
REQ-024 A watchdog SHALL count MD_WAIT cycles from 0; on reaching MD_MAX-1 without md_done, SHALL pulse md_timeout for 1 cycle and go to MD_DRAIN; md_done wins a tie.
REQ-025 stall_cnt SHALL increment by 1 in every cycle where pc_en=0 and SHALL saturate at all-ones.
REQ-026 cnt_clr SHALL zero stall_cnt next cycle and take priority over the increment.

Reset
REQ-027 While rst=1, SHALL force state=RUN, watchdog=0, stall_cnt=0, md_timeout=0.
REQ-028 While rst=1, SHALL force pc_en=ifid_en=idex_en=0 and ifid_flush=idex_flush=0.
REQ-029 Reset asserted mid-MD_WAIT SHALL abandon the wait; after rst falls, SHALL restart in RUN.

Structure
REQ-030 The state encoding (2-bit), REG_X0 = 5'd0 and the default MD_MAX SHALL reside in a shared pipeline package.
REQ-031 stall_cnt SHALL be implemented by one sub-module, sat_counter (parameterized width, inc, clr), for reuse by other performance counters.
REQ-032 The next-state/output logic and the watchdog SHALL live in pipe_hazard_ctrl; there SHALL be no other sub-modules.

Verification
REQ-033 Load x5 in EX (ex_rd=5, ex_mem_read=1), ID id_rs2=5, id_use_rs2=1 -> that cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1; stall_cnt=1.
REQ-034 Same as REQ-033 but ex_rd=0 -> no stall, stall_cnt stays 0.
REQ-035 ex_br_taken=1 together with a load-use hazard -> pc_en=1, ifid_flush=1, idex_flush=1, ifid_en=1; stall_cnt unchanged.
REQ-036 ex_md_start at cycle 0, md_done at cycle 5 -> enables 0 in cycles 1-5, MD_DRAIN in cycle 6, RUN in cycle 7; stall_cnt=5.
REQ-037 MD_MAX=8, ex_md_start with md_done never asserted -> md_timeout pulses in the 8th MD_WAIT cycle, then MD_DRAIN, then RUN.
REQ-038 rst asserted in the 3rd MD_WAIT cycle -> outputs reset immediately; after release, state=RUN, stall_cnt=0, enables 1.
